// File: rtl/window_pkg.sv
// Shared definitions for the 3x3 window generator and the filter stage that
// consumes its taps.
//   PIX_W          : pixel width (RGB332)
//   R/G/B_MSB/LSB  : RGB332 field positions inside a pixel
//   TAP_*          : window tap indices, row-major from top-left (kernel k[0..8])
//   state_t        : window generator state encoding
package window_pkg;

    localparam int PIX_W = 8;

    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    localparam int TAP_TL = 0;
    localparam int TAP_TC = 1;
    localparam int TAP_TR = 2;
    localparam int TAP_ML = 3;
    localparam int TAP_C  = 4;
    localparam int TAP_MR = 5;
    localparam int TAP_BL = 6;
    localparam int TAP_BC = 7;
    localparam int TAP_BR = 8;
    localparam int N_TAPS = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel-in / window-out bundle of the 3x3 window generator.
//   pix_in, pix_valid, sof : raster pixel stream from the source
//   pix_ready              : generator accepts pix_in this cycle
//   win, win_valid         : 9 taps (tap i at win[PIX_W*i +: PIX_W]) and strobe
//   win_x, win_y           : centre coordinates of the current window
//   frame_done             : pulse with the last window of a frame
// slave = generator side, master = source/consumer side.
interface window_3x3_gen_if #(
    parameter int PIX_W = window_pkg::PIX_W
) ();

    logic [PIX_W-1:0]                    pix_in;
    logic                                pix_valid;
    logic                                sof;
    logic                                pix_ready;
    logic [window_pkg::N_TAPS*PIX_W-1:0] win;
    logic                                win_valid;
    logic [7:0]                          win_x;
    logic [7:0]                          win_y;
    logic                                frame_done;

    modport slave (
        input  pix_in, pix_valid, sof,
        output pix_ready, win, win_valid, win_x, win_y, frame_done
    );

    modport master (
        output pix_in, pix_valid, sof,
        input  pix_ready, win, win_valid, win_x, win_y, frame_done
    );

endinterface

// File: rtl/window_3x3_gen_line_buf.sv
// line_buf: DEPTH-deep, DATA_W-wide delay line built on a RAM array with a
// registered read, advancing one entry per cycle with en high.
//   clk, rst : clock, asynchronous active-low reset (pointer only)
//   en       : shift enable
//   din      : value written on a shift
//   dout     : value written DEPTH shifts before the next shift
module line_buf #(
    parameter int DEPTH  = 200,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [DATA_W-1:0] rd_q;

    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // The read always targets the entry the *next* shift will overwrite, so
    // rd_q is usable combinationally at the shift itself. On a shift the read
    // address (ptr+1) differs from the write address (ptr).
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr_q] <= din;
        end
        rd_q <= mem[ptr_d];
    end

    assign dout = rd_q;

endmodule

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: streaming 3x3 neighbourhood generator.
//   clk  : processing clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of window_3x3_gen_if (pixel stream in, windows out)
// Pixels enter in raster order; each shift pushes one pixel through two
// line buffers and a 3x3 column pipeline. The window centre lags the input by
// WIDTH+1 shifts; out-of-image taps are zeroed from the centre coordinates.
module window_3x3_gen
    import window_pkg::*;
#(
    parameter int WIDTH  = 200,
    parameter int HEIGHT = 200,
    parameter int PIX_W  = window_pkg::PIX_W
) (
    input  logic            clk,
    input  logic            rst,
    window_3x3_gen_if.slave bus
);

    localparam logic [7:0] X_LAST    = 8'(WIDTH - 1);
    localparam logic [7:0] Y_LAST    = 8'(HEIGHT - 1);
    localparam logic [8:0] SHIFT_LAG = 9'(WIDTH);

    state_t                   state_q, state_d;
    logic [7:0]               in_x_q, in_x_d, in_y_q, in_y_d;
    logic [7:0]               cx_q, cx_d, cy_q, cy_d;
    logic [8:0]               cnt_q, cnt_d;
    logic [2:0][PIX_W-1:0]    col1_q, col1_d, col2_q, col2_d, col_new;
    logic [N_TAPS*PIX_W-1:0]  win_q, win_d, win_masked;
    logic                     win_valid_q, win_valid_d, frame_done_q, frame_done_d;
    logic [7:0]               win_x_q, win_x_d, win_y_q, win_y_d;
    logic                     pix_ready, accept, shift, emit, last;
    logic [PIX_W-1:0]         shift_pix, lb0_dout, lb1_dout;
    logic                     edge_l, edge_r, edge_t, edge_b;

    assign pix_ready = (state_q != ST_FLUSH);
    assign accept    = bus.pix_valid & pix_ready;
    // IDLE accepts without sof are discarded and do not disturb the pipeline.
    assign shift     = (accept & (bus.sof | (state_q != ST_IDLE))) | (state_q == ST_FLUSH);
    assign shift_pix = (state_q == ST_FLUSH) ? '0 : bus.pix_in;

    line_buf #(.DEPTH(WIDTH), .DATA_W(PIX_W)) u_lb0 (
        .clk(clk), .rst(rst), .en(shift), .din(shift_pix), .dout(lb0_dout)
    );
    line_buf #(.DEPTH(WIDTH), .DATA_W(PIX_W)) u_lb1 (
        .clk(clk), .rst(rst), .en(shift), .din(lb0_dout), .dout(lb1_dout)
    );

    // Newest column: row 0 two lines back, row 1 one line back, row 2 incoming.
    assign col_new[0] = lb1_dout;
    assign col_new[1] = lb0_dout;
    assign col_new[2] = shift_pix;

    assign col1_d = shift ? col2_q  : col1_q;
    assign col2_d = shift ? col_new : col2_q;

    assign edge_l = (cx_q == 8'd0);
    assign edge_r = (cx_q == X_LAST);
    assign edge_t = (cy_q == 8'd0);
    assign edge_b = (cy_q == Y_LAST);

    // Window as it stands after the current shift, with padding applied.
    for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_tap
        localparam int ROW = gi / 3;
        localparam int COL = gi % 3;
        logic [PIX_W-1:0] raw;
        logic             kill;
        if (COL == 0) begin : g_c0
            assign raw = col1_q[ROW];
        end else if (COL == 1) begin : g_c1
            assign raw = col2_q[ROW];
        end else begin : g_c2
            assign raw = col_new[ROW];
        end
        assign kill = ((COL == 0) && edge_l) || ((COL == 2) && edge_r) ||
                      ((ROW == 0) && edge_t) || ((ROW == 2) && edge_b);
        assign win_masked[PIX_W*gi +: PIX_W] = kill ? '0 : raw;
    end

    always_comb begin
        state_d      = state_q;
        in_x_d       = in_x_q;
        in_y_d       = in_y_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        cnt_d        = cnt_q;
        emit         = 1'b0;
        last         = 1'b0;
        win_d        = win_q;
        win_valid_d  = 1'b0;
        win_x_d      = win_x_q;
        win_y_d      = win_y_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_FILL, ST_RUN: begin
                if (accept && bus.sof) begin
                    // Start (or restart) a frame: this pixel is (0,0).
                    state_d = ST_FILL;
                    in_x_d  = 8'd1;
                    in_y_d  = 8'd0;
                    cx_d    = 8'd0;
                    cy_d    = 8'd0;
                    cnt_d   = '0;
                end else if (accept && (state_q != ST_IDLE)) begin
                    if (in_x_q == X_LAST) begin
                        in_x_d = 8'd0;
                        in_y_d = (in_y_q == Y_LAST) ? 8'd0 : in_y_q + 8'd1;
                    end else begin
                        in_x_d = in_x_q + 8'd1;
                    end
                    if (state_q == ST_FILL) begin
                        if (cnt_q == SHIFT_LAG) begin
                            emit    = 1'b1;
                            state_d = ST_RUN;
                        end else begin
                            cnt_d = cnt_q + 9'd1;
                        end
                    end else begin
                        emit = 1'b1;
                        if ((in_x_q == X_LAST) && (in_y_q == Y_LAST)) begin
                            state_d = ST_FLUSH;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                emit = 1'b1;
                if (cnt_q == SHIFT_LAG) begin
                    last    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (emit) begin
            win_d        = win_masked;
            win_valid_d  = 1'b1;
            win_x_d      = cx_q;
            win_y_d      = cy_q;
            frame_done_d = last;
            if (cx_q == X_LAST) begin
                cx_d = 8'd0;
                cy_d = (cy_q == Y_LAST) ? 8'd0 : cy_q + 8'd1;
            end else begin
                cx_d = cx_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            in_x_q       <= '0;
            in_y_q       <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            cnt_q        <= '0;
            col1_q       <= '0;
            col2_q       <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_x_q       <= in_x_d;
            in_y_q       <= in_y_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            cnt_q        <= cnt_d;
            col1_q       <= col1_d;
            col2_q       <= col2_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            win_x_q      <= win_x_d;
            win_y_q      <= win_y_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.pix_ready  = pix_ready;
    assign bus.win        = win_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_x      = win_x_q;
    assign bus.win_y      = win_y_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 4x3 image whose pixel (x,y) is
// 16*y + x + 1. Each scenario task drives a frame and checks its own results.
module tb_window_3x3_gen;

    localparam int W = 4;
    localparam int H = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    window_3x3_gen_if #(.PIX_W(8)) bus ();

    window_3x3_gen #(.WIDTH(W), .HEIGHT(H), .PIX_W(8)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc_cyc;
    int acc_cyc [W*H];

    logic [71:0] q_win [$];
    int          q_x   [$];
    int          q_y   [$];
    int          q_fd  [$];
    int          q_cyc [$];
    int          fd_count  = 0;
    int          gap_viol  = 0;
    bit          in_stream = 1'b0;
    logic        drove_valid = 1'b0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        drove_valid <= bus.pix_valid;
    end

    // One line per issued window.
    always @(negedge clk) begin
        if (rst_n && bus.win_valid) begin
            q_win.push_back(bus.win);
            q_x.push_back(int'(bus.win_x));
            q_y.push_back(int'(bus.win_y));
            q_fd.push_back(int'(bus.frame_done));
            q_cyc.push_back(cyc);
            if (bus.frame_done) fd_count++;
            if (in_stream && !drove_valid) gap_viol++;
            $display("window cyc=%0d x=%0d y=%0d frame_done=%0d taps=%h",
                     cyc, bus.win_x, bus.win_y, bus.frame_done, bus.win);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference window from the image definition, zero outside the image.
    function automatic logic [71:0] exp_win(input int cx, input int cy);
        logic [71:0] w;
        int r, c;
        w = '0;
        for (int i = 0; i < 9; i++) begin
            r = cy + i / 3 - 1;
            c = cx + i % 3 - 1;
            if (r >= 0 && r < H && c >= 0 && c < W) w[8*i +: 8] = 8'(16*r + c + 1);
        end
        return w;
    endfunction

    function automatic logic [71:0] pack9(input int t [9]);
        logic [71:0] w;
        for (int i = 0; i < 9; i++) w[8*i +: 8] = 8'(t[i]);
        return w;
    endfunction

    task automatic clear_log();
        q_win.delete(); q_x.delete(); q_y.delete(); q_fd.delete(); q_cyc.delete();
        fd_count = 0;
        gap_viol = 0;
    endtask

    task automatic send(input int v, input bit s);
        int t;
        @(negedge clk);
        bus.pix_in    = 8'(v);
        bus.pix_valid = 1'b1;
        bus.sof       = s;
        t = 0;
        while (!bus.pix_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++; failures++;
            $display("FAIL ready_timeout: pix_ready=0 for %0d cycles, required 1", t);
        end
        @(posedge clk);
        #1;
        last_acc_cyc  = cyc;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
    endtask

    task automatic stream_frame(input bit gaps);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
                send(16*y + x + 1, (x == 0 && y == 0));
                acc_cyc[y*W + x] = last_acc_cyc;
            end
        end
    endtask

    task automatic wait_frame_done(input int target);
        int t;
        t = 0;
        while (fd_count < target && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (fd_count < target) begin
            checks++; failures++;
            $display("FAIL frame_done_timeout: seen=%0d required=%0d", fd_count, target);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.pix_in = '0; bus.pix_valid = 1'b0; bus.sof = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.pix_ready !== 1'b1) begin failures++; $display("FAIL reset_pix_ready: got %b want 1", bus.pix_ready); end
        checks++; if (bus.win_valid !== 1'b0) begin failures++; $display("FAIL reset_win_valid: got %b want 0", bus.win_valid); end
        checks++; if (bus.win !== 72'd0) begin failures++; $display("FAIL reset_win: got %h want 0", bus.win); end
        checks++; if (bus.win_x !== 8'd0 || bus.win_y !== 8'd0) begin failures++; $display("FAIL reset_xy: got %0d,%0d want 0,0", bus.win_x, bus.win_y); end
        checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_window();
        clear_log();
        stream_frame(1'b0);
        wait_frame_done(1);
        checks++;
        if (q_win.size() != 12) begin failures++; $display("FAIL first_count: got %0d windows want 12", q_win.size()); end
        if (q_win.size() > 0) begin
            checks++; if (q_cyc[0] != acc_cyc[5]) begin failures++; $display("FAIL first_latency: window at cycle %0d want %0d", q_cyc[0], acc_cyc[5]); end
            checks++; if (q_x[0] != 0 || q_y[0] != 0) begin failures++; $display("FAIL first_centre: got %0d,%0d want 0,0", q_x[0], q_y[0]); end
            checks++; if (q_win[0] !== pack9('{0,0,0,0,1,2,0,17,18})) begin failures++; $display("FAIL first_taps: got %h want %h", q_win[0], pack9('{0,0,0,0,1,2,0,17,18})); end
        end
    endtask

    task automatic test_interior_and_edge();
        clear_log();
        stream_frame(1'b0);
        wait_frame_done(1);
        checks++;
        if (q_win.size() != 12) begin failures++; $display("FAIL interior_count: got %0d want 12", q_win.size()); end
        if (q_win.size() >= 6) begin
            checks++; if (q_x[5] != 1 || q_y[5] != 1) begin failures++; $display("FAIL centre11_xy: got %0d,%0d want 1,1", q_x[5], q_y[5]); end
            checks++; if (q_win[5] !== pack9('{1,2,3,17,18,19,33,34,35})) begin failures++; $display("FAIL centre11_taps: got %h want %h", q_win[5], pack9('{1,2,3,17,18,19,33,34,35})); end
            checks++; if (q_x[3] != 3 || q_y[3] != 0) begin failures++; $display("FAIL centre30_xy: got %0d,%0d want 3,0", q_x[3], q_y[3]); end
            checks++; if (q_win[3] !== pack9('{0,0,0,3,4,0,19,20,0})) begin failures++; $display("FAIL centre30_taps: got %h want %h", q_win[3], pack9('{0,0,0,3,4,0,19,20,0})); end
        end
    endtask

    task automatic test_end_of_frame();
        int low;
        bit after;
        clear_log();
        stream_frame(1'b0);
        low = 0;
        after = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!bus.pix_ready) low++;
            if (i == 5) after = bus.pix_ready;
        end
        wait_frame_done(1);
        checks++; if (low != 5) begin failures++; $display("FAIL flush_ready_low: got %0d cycles want 5", low); end
        checks++; if (after !== 1'b1) begin failures++; $display("FAIL flush_ready_return: got %b want 1", after); end
        checks++; if (q_win.size() != 12) begin failures++; $display("FAIL eof_count: got %0d want 12", q_win.size()); end
        checks++; if (fd_count != 1) begin failures++; $display("FAIL eof_frame_done_count: got %0d want 1", fd_count); end
        if (q_win.size() == 12) begin
            checks++; if (q_x[11] != 3 || q_y[11] != 2 || q_fd[11] != 1) begin failures++; $display("FAIL last_window: got x=%0d y=%0d fd=%0d want 3,2,1", q_x[11], q_y[11], q_fd[11]); end
            checks++; if (q_win[11] !== pack9('{19,20,0,35,36,0,0,0,0})) begin failures++; $display("FAIL last_taps: got %h want %h", q_win[11], pack9('{19,20,0,35,36,0,0,0,0})); end
            for (int k = 0; k < 12; k++) begin
                checks++;
                if (q_win[k] !== exp_win(k % W, k / W) || q_x[k] != k % W || q_y[k] != k / W || q_fd[k] != int'(k == 11)) begin
                    failures++;
                    $display("FAIL eof_seq[%0d]: got x=%0d y=%0d fd=%0d taps=%h want x=%0d y=%0d taps=%h",
                             k, q_x[k], q_y[k], q_fd[k], q_win[k], k % W, k / W, exp_win(k % W, k / W));
                end
            end
        end
    endtask

    task automatic test_gaps();
        clear_log();
        in_stream = 1'b1;
        stream_frame(1'b1);
        in_stream = 1'b0;
        wait_frame_done(1);
        checks++; if (gap_viol != 0) begin failures++; $display("FAIL gap_win_valid: got %0d windows without a shift want 0", gap_viol); end
        checks++; if (q_win.size() != 12) begin failures++; $display("FAIL gap_count: got %0d want 12", q_win.size()); end
        if (q_win.size() == 12) begin
            for (int k = 0; k < 12; k++) begin
                checks++;
                if (q_win[k] !== exp_win(k % W, k / W) || q_x[k] != k % W || q_y[k] != k / W) begin
                    failures++;
                    $display("FAIL gap_seq[%0d]: got x=%0d y=%0d taps=%h want x=%0d y=%0d taps=%h",
                             k, q_x[k], q_y[k], q_win[k], k % W, k / W, exp_win(k % W, k / W));
                end
            end
        end
    endtask

    task automatic test_discard_and_abort();
        clear_log();
        repeat (3) send(8'h99, 1'b0);
        for (int i = 0; i < 6; i++) send(16*(i / W) + (i % W) + 1, (i == 0));
        stream_frame(1'b0);
        wait_frame_done(1);
        checks++; if (fd_count != 1) begin failures++; $display("FAIL abort_frame_done: got %0d want 1", fd_count); end
        checks++; if (q_win.size() != 13) begin failures++; $display("FAIL abort_count: got %0d want 13", q_win.size()); end
        if (q_win.size() == 13) begin
            checks++; if (q_win[0] !== pack9('{0,0,0,0,1,2,0,17,18}) || q_fd[0] != 0) begin failures++; $display("FAIL abort_first: got %h fd=%0d want %h fd=0", q_win[0], q_fd[0], pack9('{0,0,0,0,1,2,0,17,18})); end
            for (int k = 0; k < 12; k++) begin
                checks++;
                if (q_win[k+1] !== exp_win(k % W, k / W) || q_x[k+1] != k % W || q_y[k+1] != k / W) begin
                    failures++;
                    $display("FAIL abort_seq[%0d]: got x=%0d y=%0d taps=%h want x=%0d y=%0d taps=%h",
                             k, q_x[k+1], q_y[k+1], q_win[k+1], k % W, k / W, exp_win(k % W, k / W));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        clear_log();
        for (int i = 0; i < 8; i++) send(16*(i / W) + (i % W) + 1, (i == 0));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.win !== 72'd0 || bus.win_valid !== 1'b0) begin failures++; $display("FAIL async_win: got %h valid=%b want 0 0", bus.win, bus.win_valid); end
        checks++; if (bus.win_x !== 8'd0 || bus.win_y !== 8'd0 || bus.frame_done !== 1'b0) begin failures++; $display("FAIL async_xy: got %0d,%0d fd=%b want 0,0,0", bus.win_x, bus.win_y, bus.frame_done); end
        checks++; if (bus.pix_ready !== 1'b1) begin failures++; $display("FAIL async_ready: got %b want 1", bus.pix_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        stream_frame(1'b0);
        wait_frame_done(1);
        checks++; if (q_win.size() != 12 || fd_count != 1) begin failures++; $display("FAIL post_reset_count: got %0d windows fd=%0d want 12 1", q_win.size(), fd_count); end
        if (q_win.size() == 12) begin
            for (int k = 0; k < 12; k++) begin
                checks++;
                if (q_win[k] !== exp_win(k % W, k / W) || q_x[k] != k % W || q_y[k] != k / W) begin
                    failures++;
                    $display("FAIL post_reset_seq[%0d]: got x=%0d y=%0d taps=%h want x=%0d y=%0d taps=%h",
                             k, q_x[k], q_y[k], q_win[k], k % W, k / W, exp_win(k % W, k / W));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_window();
        test_interior_and_edge();
        test_end_of_frame();
        test_gaps();
        test_discard_and_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
